// File: rtl/twiddle_seq.sv
// twiddle_seq: multiplies a stream of complex samples by W8^k, with k = sample count mod 4.
// Even k needs only swaps and negations, so the result is ready one cycle after accept.
// Odd k needs a 1/sqrt(2) scaling. One shared div_sqrt_2 does the real part, then the
// imaginary part, so the result is ready three cycles after accept.
// Optional feature: define TWIDDLE_SEQ_SOF_EN to add the in_sof input.
// A sample accepted with in_sof=1 uses k=0, and the index restarts from there.

// D(x) = x/2 + x/8 + x/16 + x/64 (~ x/sqrt(2)), arithmetic shifts, W-bit wrapping adds.
module div_sqrt_2 #(
    parameter int unsigned W = 8
) (
    input  logic signed [W-1:0] x_i,
    output logic signed [W-1:0] y_o
);

    // Pure combinational shift-and-add.
    always_comb begin
        y_o = (x_i >>> 1) + (x_i >>> 3) + (x_i >>> 4) + (x_i >>> 6);
    end

endmodule

module twiddle_seq #(
    parameter  int unsigned N = 3,
    localparam int unsigned W = 2 ** N
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] in_re,
    input  logic signed [W-1:0] in_im,
`ifdef TWIDDLE_SEQ_SOF_EN
    input  logic                in_sof,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] out_re,
    output logic signed [W-1:0] out_im,
    output logic [1:0]          k_idx
);

    typedef enum logic [1:0] {
        StIdle,
        StMulRe,
        StMulIm,
        StOut
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          k_q, k_d;
    logic signed [W-1:0] op_re_q, op_re_d;
    logic signed [W-1:0] op_im_q, op_im_d;
    logic signed [W-1:0] out_re_q, out_re_d;
    logic signed [W-1:0] out_im_q, out_im_d;
    logic                out_valid_q, out_valid_d;
    logic                in_ready_q, in_ready_d;

    logic                accept;
    logic [1:0]          k_eff;
    logic signed [W-1:0] sum_ab, dif_ba, neg_sum, neg_a;
    logic signed [W-1:0] div_in, div_out;

    // The divider input follows the phase: real operand in StMulRe, imaginary in StMulIm.
    always_comb begin
        div_in = (state_q == StMulIm) ? op_im_q : op_re_q;
    end

    div_sqrt_2 #(
        .W (W)
    ) u_div (
        .x_i (div_in),
        .y_o (div_out)
    );

    // Next-state, datapath and handshake logic.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        op_re_d     = op_re_q;
        op_im_d     = op_im_q;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;

        accept  = in_valid & in_ready_q;
        k_eff   = k_q;
`ifdef TWIDDLE_SEQ_SOF_EN
        if (in_sof) begin
            k_eff = 2'd0;
        end
`endif
        sum_ab  = in_re + in_im;
        dif_ba  = in_im - in_re;
        neg_sum = -in_re - in_im;
        neg_a   = -in_re;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    k_d        = 2'(k_eff + 2'd1);
                    in_ready_d = 1'b0;
                    unique case (k_eff)
                        2'd0: begin
                            out_re_d    = in_re;
                            out_im_d    = in_im;
                            out_valid_d = 1'b1;
                            state_d     = StOut;
                        end
                        2'd1: begin
                            op_re_d = sum_ab;
                            op_im_d = dif_ba;
                            state_d = StMulRe;
                        end
                        2'd2: begin
                            out_re_d    = in_im;
                            out_im_d    = neg_a;
                            out_valid_d = 1'b1;
                            state_d     = StOut;
                        end
                        default: begin
                            op_re_d = dif_ba;
                            op_im_d = neg_sum;
                            state_d = StMulRe;
                        end
                    endcase
                end
            end
            StMulRe: begin
                out_re_d = div_out;
                state_d  = StMulIm;
            end
            StMulIm: begin
                out_im_d    = div_out;
                out_valid_d = 1'b1;
                state_d     = StOut;
            end
            default: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = StIdle;
                end
            end
        endcase
    end

    // All state registers, with a synchronous reset that drops any sample in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            k_q         <= 2'd0;
            op_re_q     <= '0;
            op_im_q     <= '0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            op_re_q     <= op_re_d;
            op_im_q     <= op_im_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
    assign k_idx     = k_q;

endmodule

// File: tb/tb_twiddle_seq.sv
// Bench for twiddle_seq (N=3, W=8). The driver pushes model results into a scoreboard.
// The negedge monitor pops results, checks data and latency, and checks in_ready and k_idx.
module tb_twiddle_seq;

    localparam int N = 3;
    localparam int W = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic signed [W-1:0] in_re = '0;
    logic signed [W-1:0] in_im = '0;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic signed [W-1:0] out_re;
    logic signed [W-1:0] out_im;
    logic [1:0]          k_idx;
`ifdef TWIDDLE_SEQ_SOF_EN
    logic                in_sof = 1'b0;
`endif

    always #5 clk = ~clk;

    twiddle_seq #(
        .N (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
`ifdef TWIDDLE_SEQ_SOF_EN
        .in_sof    (in_sof),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .k_idx     (k_idx)
    );

    typedef struct {
        int re;
        int im;
        int cyc;
        int lat;
    } exp_t;

    exp_t sbq[$];
    int   n_chk    = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled
    int   model_k  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic int wrap(input int x);
        int m;
        m = x & ((1 << W) - 1);
        if (m >= (1 << (W - 1))) m -= (1 << W);
        return m;
    endfunction

    function automatic int fdiv(input int x, input int d);
        int q;
        q = x / d;
        if ((x % d != 0) && (x < 0)) q -= 1;
        return q;
    endfunction

    function automatic int dsq(input int x);
        return wrap(fdiv(x, 2) + fdiv(x, 8) + fdiv(x, 16) + fdiv(x, 64));
    endfunction

    function automatic void rot(input int a, input int b, input int k,
                                output int re, output int im);
        case (k)
            0: begin re = a; im = b; end
            1: begin re = dsq(wrap(a + b)); im = dsq(wrap(b - a)); end
            2: begin re = b; im = wrap(-a); end
            default: begin re = dsq(wrap(b - a)); im = dsq(wrap(-a - b)); end
        endcase
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic bound_fail(input string name);
        n_chk++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // ---------------- driver ----------------
    task automatic send(input int a, input int b, input bit sof = 1'b0);
        int   g;
        int   k;
        exp_t e;
        g = 0;
        // While busy, wiggle the inputs; a busy DUT must ignore them.
        while (!in_ready && g < 200) begin
            in_valid = 1'($urandom_range(0, 1));
            in_re    = W'($urandom);
            in_im    = W'($urandom);
            @(posedge clk); #1;
            g++;
        end
        if (!in_ready) begin
            bound_fail("send_wait_ready");
            in_valid = 1'b0;
            return;
        end
        in_valid = 1'b1;
        in_re    = W'(a);
        in_im    = W'(b);
`ifdef TWIDDLE_SEQ_SOF_EN
        in_sof   = sof;
`endif
        k = sof ? 0 : model_k;
        rot(wrap(a), wrap(b), k, e.re, e.im);
        e.cyc = cyc;
        e.lat = (k % 2 == 1) ? 3 : 1;
        sbq.push_back(e);
        model_k = (k + 1) % 4;
        @(posedge clk); #1;
        in_valid = 1'b0;
`ifdef TWIDDLE_SEQ_SOF_EN
        in_sof   = 1'b0;
`endif
        in_re    = W'($urandom);
        in_im    = W'($urandom);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sbq.size() != 0 && g < 300) begin
            @(posedge clk); #1;
            g++;
        end
        if (sbq.size() != 0) bound_fail("drain");
        in_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        sbq.delete();
        model_k = 0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // ---------------- monitor ----------------
    bit busy    = 1'b0;
    bit prev_ov = 1'b0;
    int mon_k   = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            busy    = 1'b0;
            prev_ov = 1'b0;
            mon_k   = 0;
        end else begin
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
            check("in_ready", int'(in_ready), busy ? 0 : 1);
            if (in_ready) check("k_idx", int'(k_idx), mon_k);
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    bound_fail("spurious_out_valid");
                end else begin
                    e = sbq[0];
                    if (!prev_ov) check("latency", cyc - e.cyc, e.lat);
                    check("out_re", int'(out_re), e.re);
                    check("out_im", int'(out_im), e.im);
                    if (out_ready) begin
                        void'(sbq.pop_front());
                        busy = 1'b0;
                    end
                end
            end
            if (in_valid && in_ready) begin
                busy = 1'b1;
`ifdef TWIDDLE_SEQ_SOF_EN
                mon_k = in_sof ? 1 : (mon_k + 1) % 4;
`else
                mon_k = (mon_k + 1) % 4;
`endif
            end
            prev_ov = out_valid && !out_ready;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_re", int'(out_re), 0);
        check("rst_out_im", int'(out_im), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_k_idx", int'(k_idx), 0);

        // Four (64,0) samples walk through all k, then k wraps back to 0.
        for (int i = 0; i < 4; i++) send(64, 0);
        drain();
        check("k_wrap", int'(k_idx), 0);

        // k=1 with a+b overflowing: (100,100) -> a+b wraps to -56 -> (-40, 0).
        send(1, 1);
        send(100, 100);
        drain();

        // k=2 swap/negate, then k=3.
        send(10, 20);
        send(5, -7);
        drain();

        // Stall in OUT: output must hold, and new offers must be ignored.
        rdy_mode = 2;
        send(33, -20);
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_re    = W'($urandom);
            in_im    = W'($urandom);
            check("hold_valid", int'(out_valid), 1);
            check("hold_k", int'(k_idx), model_k);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rdy_mode = 0;
        drain();

        // Reset while in MUL_IM drops the sample; the next sample uses k=0.
        send(50, 30);
        @(posedge clk); #1;
        pulse_reset();
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_k_idx", int'(k_idx), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        send(64, 0);
        drain();

        // Random data with random back-pressure and gaps.
        rdy_mode = 1;
        for (int i = 0; i < 60; i++) begin
            send(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        drain();
        rdy_mode = 0;

`ifdef TWIDDLE_SEQ_SOF_EN
        pulse_reset();
        send(7, 9);
        send(12, -3);
        send(64, 0, 1'b1);
        send(64, 0);
        drain();
        check("sof_next_k", int'(k_idx), 2);
`endif

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/twiddle_seq.md
TWIDDLE_SEQ -- requirements
Module: twiddle_seq

Interface
REQ-001 SHALL have parameter N, default 3; sample component width W = 2**N bits, two's complement.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset: synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  input sample offered.
REQ-005 SHALL have port in_ready  output  1  block can accept a sample.
REQ-006 SHALL have port in_re, in_im  input  W each  complex input sample a + jb.
REQ-007 SHALL have port out_valid  output  1  result held on out_re/out_im.
REQ-008 SHALL have port out_ready  input  1  downstream accepts result.
REQ-009 SHALL have port out_re, out_im  output  W each  twiddled sample.
REQ-010 SHALL have port k_idx  output  2  twiddle index applied to the sample currently held or next to be accepted.

Function
REQ-011 SHALL apply W8^k to each accepted sample, k = sample count modulo 4: k0 -> (a, b); k1 -> D(a+b), D(b-a); k2 -> (b, -a); k3 -> D(b-a), D(-a-b).
REQ-012 D(x) SHALL equal (x>>>1)+(x>>>3)+(x>>>4)+(x>>>6), arithmetic shifts, W-bit wrapping adds, computed by exactly one instantiated div_sqrt_2 shared between real and imaginary parts.
REQ-013 All sums/negations (a+b, b-a, -a-b, -a) SHALL be W-bit, wrapping modulo 2**W; no saturation.
REQ-014 FSM states SHALL be IDLE, MUL_RE, MUL_IM, OUT.
REQ-015 in_ready SHALL be 1 only in IDLE; accept = in_valid & in_ready.
REQ-016 IDLE, accept with k even: outputs registered, next state OUT (out_valid one cycle after accept).
REQ-017 IDLE, accept with k odd: operand pair registered, next MUL_RE; MUL_RE drives div_sqrt_2 with real operand, registers out_re, next MUL_IM; MUL_IM likewise for out_im, next OUT (out_valid three cycles after accept).
REQ-018 OUT: out_valid=1, outputs stable; out_ready=1 -> IDLE next cycle; out_ready=0 -> hold indefinitely.
REQ-019 k SHALL increment on each accept, wrapping 3 -> 0; k_idx = k.
REQ-020 Input changes outside IDLE SHALL not affect the sample in flight.

Reset
REQ-021 rst=1 at any clock edge SHALL force IDLE, k=0, out_valid=0, out_re=out_im=0; in_ready=1 in the cycle after rst deasserts.
REQ-022 rst asserted mid-operation (MUL_RE/MUL_IM/OUT) SHALL discard the sample in flight with no out_valid pulse.

Configuration
REQ-023 Macro TWIDDLE_SEQ_SOF_EN defined: extra port in_sof input 1; accept with in_sof=1 SHALL use k=0 for that sample and set next k=1.
REQ-024 Macro TWIDDLE_SEQ_SOF_EN undefined: in_sof port absent; k driven by count only.

Verification (N=3, W=8)
REQ-025 rst, then four samples (64,0), out_ready=1 -> outputs (64,0), (45,-45), (0,-64), (-45,-45); k_idx wraps to 0.
REQ-026 k=1 sample (100,100) -> a+b wraps to -56 -> out (-40, 0).
REQ-027 k=2 sample (10,20) -> out (20,-10), out_valid one cycle after accept; k=1 sample -> out_valid three cycles after accept, in_ready=0 throughout.
REQ-028 out_ready=0 for 5 cycles in OUT -> out_valid and data held, in_ready=0, new in_valid ignored; k unchanged.
REQ-029 rst pulsed while in MUL_IM -> no out_valid, next sample uses k=0.
REQ-030 With TWIDDLE_SEQ_SOF_EN: after two samples, in_sof=1 with (64,0) -> out (64,0), next sample takes k=1.
